// File: rtl/sisa_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : sisa_decode_stage
// Description : Registered instruction-decode stage for the sCPU. Classifies
//               each accepted instruction word as add / li / bne / nop,
//               extracts rd, rs and a zero-extended immediate, and holds the
//               result in a one-entry valid/ready register with flush.
//
// Ports       : clk, rst            - clock, synchronous active-high reset
//               in_valid/in_instr   - instruction from fetch
//               in_ready            - stage can accept this cycle
//               flush               - drop the held entry (taken branch)
//               out_valid/out_ready - handshake towards execute
//               out_add/li/bne/nop  - one-hot instruction type
//               out_op/rd/rs/imm    - raw opcode and decoded fields
//               cnt_add/li/bne/nop  - saturating retire counters
//                                     (only with SISA_DEC_STATS_EN)
//
// Options     : define SISA_DEC_STATS_EN to add the retire counters.
//
// Revision    : 1.0 - initial release
// ============================================================================
module sisa_decode_stage #(
    parameter int INSTR_W = 8,
    parameter int OP_W    = 2,
    parameter int REG_W   = 2,
    parameter int IMM_W   = 4,
    parameter int ADD_OP  = 0,
    parameter int LI_OP   = 2,
    parameter int BNE_OP  = 3,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_add,
    output logic               out_li,
    output logic               out_bne,
    output logic               out_nop,
    output logic [OP_W-1:0]    out_op,
    output logic [REG_W-1:0]   out_rd,
    output logic [REG_W-1:0]   out_rs,
    output logic [INSTR_W-1:0] out_imm
`ifdef SISA_DEC_STATS_EN
    ,
    output logic [CNT_W-1:0]   cnt_add,
    output logic [CNT_W-1:0]   cnt_li,
    output logic [CNT_W-1:0]   cnt_bne,
    output logic [CNT_W-1:0]   cnt_nop
`endif
);

    // ------------------------------------------------------------------------
    // Field positions inside the instruction word
    // ------------------------------------------------------------------------
    localparam int c_RD_MSB = INSTR_W - OP_W - 1;
    localparam int c_RS_MSB = INSTR_W - OP_W - REG_W - 1;

    // ------------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ------------------------------------------------------------------------
    logic [OP_W-1:0]    w_op;
    logic               w_is_add;
    logic               w_is_li;
    logic               w_is_bne;
    logic               w_is_nop;
    logic [REG_W-1:0]   w_rd;
    logic [REG_W-1:0]   w_rs;
    logic [INSTR_W-1:0] w_imm;

    assign w_op = in_instr[INSTR_W-1 -: OP_W];

    // Chained compares give add > li > bne precedence when opcode
    // parameters alias, so the type stays one-hot.
    assign w_is_add = (w_op == OP_W'(ADD_OP));
    assign w_is_li  = !w_is_add && (w_op == OP_W'(LI_OP));
    assign w_is_bne = !w_is_add && !w_is_li && (w_op == OP_W'(BNE_OP));
    assign w_is_nop = !(w_is_add || w_is_li || w_is_bne);

    assign w_rd  = in_instr[c_RD_MSB -: REG_W];
    assign w_rs  = in_instr[c_RS_MSB -: REG_W];
    assign w_imm = INSTR_W'(in_instr[IMM_W-1:0]);

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    logic r_valid;
    logic w_accept;
    logic w_consume;

    // Flush frees the slot even when execute is stalled, so fetch can
    // deliver the branch target in the same cycle.
    assign in_ready  = !r_valid || out_ready || flush;
    assign w_accept  = in_valid && in_ready;
    assign w_consume = r_valid && out_ready && !flush;

    // ------------------------------------------------------------------------
    // Held entry
    // ------------------------------------------------------------------------
    logic               r_add;
    logic               r_li;
    logic               r_bne;
    logic               r_nop;
    logic [OP_W-1:0]    r_op;
    logic [REG_W-1:0]   r_rd;
    logic [REG_W-1:0]   r_rs;
    logic [INSTR_W-1:0] r_imm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_add   <= 1'b0;
            r_li    <= 1'b0;
            r_bne   <= 1'b0;
            r_nop   <= 1'b0;
            r_op    <= '0;
            r_rd    <= '0;
            r_rs    <= '0;
            r_imm   <= '0;
        end else if (w_accept) begin
            // A new word wins over consume/flush of the old one.
            r_valid <= 1'b1;
            r_add   <= w_is_add;
            r_li    <= w_is_li;
            r_bne   <= w_is_bne;
            r_nop   <= w_is_nop;
            r_op    <= w_op;
            r_rd    <= w_rd;
            r_rs    <= w_rs;
            r_imm   <= w_imm;
        end else if (w_consume || flush) begin
            // Emptied slot reads as all-zero rather than stale fields.
            r_valid <= 1'b0;
            r_add   <= 1'b0;
            r_li    <= 1'b0;
            r_bne   <= 1'b0;
            r_nop   <= 1'b0;
            r_op    <= '0;
            r_rd    <= '0;
            r_rs    <= '0;
            r_imm   <= '0;
        end
    end

    assign out_valid = r_valid;
    assign out_add   = r_add;
    assign out_li    = r_li;
    assign out_bne   = r_bne;
    assign out_nop   = r_nop;
    assign out_op    = r_op;
    assign out_rd    = r_rd;
    assign out_rs    = r_rs;
    assign out_imm   = r_imm;

    // ------------------------------------------------------------------------
    // Retire statistics
    // ------------------------------------------------------------------------
`ifdef SISA_DEC_STATS_EN
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt_add;
    logic [CNT_W-1:0] r_cnt_li;
    logic [CNT_W-1:0] r_cnt_bne;
    logic [CNT_W-1:0] r_cnt_nop;

    // Only a consume is a retire; flushed entries never reach here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_add <= '0;
            r_cnt_li  <= '0;
            r_cnt_bne <= '0;
            r_cnt_nop <= '0;
        end else if (w_consume) begin
            if (r_add && (r_cnt_add != c_CNT_MAX)) r_cnt_add <= r_cnt_add + CNT_W'(1);
            if (r_li  && (r_cnt_li  != c_CNT_MAX)) r_cnt_li  <= r_cnt_li  + CNT_W'(1);
            if (r_bne && (r_cnt_bne != c_CNT_MAX)) r_cnt_bne <= r_cnt_bne + CNT_W'(1);
            if (r_nop && (r_cnt_nop != c_CNT_MAX)) r_cnt_nop <= r_cnt_nop + CNT_W'(1);
        end
    end

    assign cnt_add = r_cnt_add;
    assign cnt_li  = r_cnt_li;
    assign cnt_bne = r_cnt_bne;
    assign cnt_nop = r_cnt_nop;
`else
    // Counter width only matters when statistics are built in.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule
`default_nettype wire

// File: doc/sisa_decode_stage.md
# sisa_decode_stage

Registered instruction-decode stage for the sCPU, generalising the combinational 2-bit opcode type decoder into a parametrised, handshaked pipeline stage. Accepts one instruction word per cycle from fetch, classifies it as add / li / bne / nop, extracts register and immediate fields, and presents the result to execute through a one-entry valid/ready register with flush support. Optional saturating per-type retire counters provide instruction-mix statistics.

## Interface
- `INSTR_W`, 8: instruction word width; opcode occupies the top `OP_W` bits.
- `OP_W`, 2: opcode width, minimum 2.
- `REG_W`, 2: register-index width; `rd` = bits [INSTR_W-OP_W-1 -: REG_W], `rs` = next REG_W bits below.
- `IMM_W`, 4: immediate width; immediate = bits [IMM_W-1:0], zero-extended.
- `ADD_OP`, 0: opcode value for add. `LI_OP`, 2: for li. `BNE_OP`, 3: for bne. Any other value is nop.
- `CNT_W`, 16: statistics counter width (used only with `SISA_DEC_STATS_EN`).
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: fetch presents an instruction.
- `in_instr` in INSTR_W: instruction word.
- `in_ready` out 1: stage can accept this cycle.
- `flush` in 1: discard the held instruction (taken branch).
- `out_valid` out 1: decoded instruction held.
- `out_ready` in 1: execute consumes this cycle.
- `out_add`, `out_li`, `out_bne`, `out_nop` out 1 each: one-hot type, exactly one high when `out_valid`.
- `out_op` out OP_W: raw opcode.
- `out_rd`, `out_rs` out REG_W: register fields.
- `out_imm` out INSTR_W: zero-extended immediate.
- `cnt_add`, `cnt_li`, `cnt_bne`, `cnt_nop` out CNT_W each: retire counts (present only with macro).

## Operation
- Accept: `in_valid && in_ready`. `in_ready = !out_valid || out_ready || flush` (combinational, no dependency on `in_valid`).
- On accept, register all decoded fields and set `out_valid`=1.
- Consume: `out_valid && out_ready && !flush`; clears `out_valid` unless a new accept occurs the same cycle (back-to-back, full throughput).
- Flush: clears the held entry regardless of `out_ready`; flushed entry is not a retire. An instruction accepted in the same cycle as `flush` is kept (flush applies to the old entry only).
- Stall: `out_valid && !out_ready && !flush` holds all outputs stable; `in_ready`=0.
- Type decode: opcode equal to `ADD_OP`/`LI_OP`/`BNE_OP` sets the matching flag; all other codes set `out_nop`. If parameters alias (e.g. `ADD_OP==LI_OP`), precedence add > li > bne.
- Type flags and fields are don't-care when `out_valid`=0 but are driven to 0 by reset and by the held-clear path.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 instruction/cycle when `out_ready` held high.
- Reset values: `out_valid`=0, all type flags 0, `out_op`/`out_rd`/`out_rs`/`out_imm`=0, all counters 0; `in_ready`=1 the cycle after reset deasserts (and during reset it reads 1, accepts ignored).
- Reset mid-stall: held entry discarded, no counter increment.
- Reset has priority over flush, accept and consume.

## Configuration
- `SISA_DEC_STATS_EN` defined: four CNT_W counters; each consume (retire) increments the counter of the retiring type by 1; counters saturate at all-ones, never wrap; flushed entries not counted.
- Undefined: counters and `cnt_*` ports absent; no counter logic synthesised.

## Test plan
- Reset then stream 8'h00, 8'h9A, 8'hF3, 8'h40 with `out_ready`=1 -> one cycle later each: add; li rd=1 rs=2 imm=8'h0A; bne rd=3 rs=0 imm=8'h03; nop; `out_valid` continuous.
- Accept 8'h9A, hold `out_ready`=0 for 5 cycles -> outputs stable, `in_ready`=0, next word not accepted until `out_ready`=1.
- Held 8'hF3 with `out_ready`=0, assert `flush` with `in_valid` carrying 8'h05 -> next cycle `out_valid`=1 holding add rd=0 rs=1 imm=5; bne never retired (`cnt_bne` unchanged).
- Assert `rst` while entry stalled -> next cycle `out_valid`=0, all outputs and counters 0.
- With `SISA_DEC_STATS_EN`, `CNT_W`=2: retire 5 adds -> `cnt_add`=3 (saturated), others 0.
- `OP_W`=3, `INSTR_W`=12, `LI_OP`=5: word 12'hA7F -> li flag, opcode 5; opcode 1 -> nop.
